// File: rtl/freelist.sv
// Physical-register free list for a 2-wide rename stage: circular queue of free
// physical registers with speculative/committed heads and flush recovery.
module freelist #(
  parameter int PREG_NUM = 64,
  parameter int AREG_NUM = 32,
  parameter int PREG_W   = 6,
  parameter int FL_DEPTH = 32,
  parameter int PTR_W    = 6
) (
  input  logic              clock,
  input  logic              reset,
  output logic [PREG_W-1:0] fl2rn_instr0prd,
  output logic              fl2rn_instr0prd_valid,
  output logic [PREG_W-1:0] fl2rn_instr1prd,
  output logic              fl2rn_instr1prd_valid,
  input  logic              rn2fl_instr0_alloc,
  input  logic              rn2fl_instr1_alloc,
  input  logic              rob2fl_free0_valid,
  input  logic [PREG_W-1:0] rob2fl_free0_preg,
  input  logic              rob2fl_free1_valid,
  input  logic [PREG_W-1:0] rob2fl_free1_preg,
  input  logic [1:0]        rob2fl_commit_alloc_cnt,
  input  logic              flush_valid,
  output logic [PTR_W-1:0]  fl_count,
  output logic              fl_err
);

  localparam int IDX_W = PTR_W - 1;

  logic [PREG_W-1:0] ent_r [FL_DEPTH];
  logic [PTR_W-1:0]  spec_head_r;
  logic [PTR_W-1:0]  arch_head_r;
  logic [PTR_W-1:0]  tail_r;
  logic              err_r;

  logic [PTR_W-1:0]  count_s;
  logic              alloc_err_s;
  logic [1:0]        alloc_n_s;
  logic [1:0]        commit_n_s;
  logic              commit_err_s;
  logic [1:0]        free_n_s;
  logic              push_err_s;
  logic [PTR_W-1:0]  arch_head_next_s;
  logic [PTR_W-1:0]  spec_head_next_s;
  logic [PTR_W-1:0]  tail_next_s;
  logic [IDX_W-1:0]  head1_idx_s;
  logic [IDX_W-1:0]  free1_idx_s;

  // Next-state computation for pointers and protocol-error detection.
  always_comb begin
    count_s = tail_r - spec_head_r;

    alloc_err_s = 1'b0;
    if (flush_valid) begin
      alloc_err_s = 1'b0;
    end else begin
      alloc_err_s = (rn2fl_instr1_alloc & ~rn2fl_instr0_alloc)
                  | (rn2fl_instr0_alloc & (count_s == PTR_W'(0)))
                  | (rn2fl_instr1_alloc & (count_s < PTR_W'(2)));
    end

    alloc_n_s = 2'd0;
    if (flush_valid || alloc_err_s) begin
      alloc_n_s = 2'd0;
    end else begin
      alloc_n_s = {1'b0, rn2fl_instr0_alloc} + {1'b0, rn2fl_instr1_alloc};
    end

    commit_n_s   = 2'd0;
    commit_err_s = 1'b0;
    case (rob2fl_commit_alloc_cnt)
      2'd3: begin
        commit_n_s   = 2'd0;
        commit_err_s = 1'b1;
      end
      default: begin
        commit_n_s   = rob2fl_commit_alloc_cnt;
        commit_err_s = PTR_W'(rob2fl_commit_alloc_cnt) > (spec_head_r - arch_head_r);
      end
    endcase
    arch_head_next_s = arch_head_r + PTR_W'(commit_n_s);

    // Occupancy is measured against the committed head so in-flight allocations stay protected.
    free_n_s   = {1'b0, rob2fl_free0_valid} + {1'b0, rob2fl_free1_valid};
    push_err_s = (free_n_s != 2'd0) &&
                 ((tail_r - arch_head_next_s + PTR_W'(free_n_s)) > PTR_W'(FL_DEPTH));
    if (push_err_s) begin
      tail_next_s = tail_r;
    end else begin
      tail_next_s = tail_r + PTR_W'(free_n_s);
    end

    if (flush_valid) begin
      spec_head_next_s = arch_head_next_s;
    end else begin
      spec_head_next_s = spec_head_r + PTR_W'(alloc_n_s);
    end

    head1_idx_s = spec_head_r[IDX_W-1:0] + IDX_W'(1);
    free1_idx_s = tail_r[IDX_W-1:0] + IDX_W'(rob2fl_free0_valid);
  end

  // State update: reset image, entry writes and pointer advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        ent_r[i] <= PREG_W'(AREG_NUM + i);
      end
      spec_head_r <= PTR_W'(0);
      arch_head_r <= PTR_W'(0);
      tail_r      <= PTR_W'(FL_DEPTH);
      err_r       <= 1'b0;
    end else begin
      if (!push_err_s && rob2fl_free0_valid) begin
        ent_r[tail_r[IDX_W-1:0]] <= rob2fl_free0_preg;
      end
      if (!push_err_s && rob2fl_free1_valid) begin
        ent_r[free1_idx_s] <= rob2fl_free1_preg;
      end
      spec_head_r <= spec_head_next_s;
      arch_head_r <= arch_head_next_s;
      tail_r      <= tail_next_s;
      err_r       <= err_r | alloc_err_s | commit_err_s | push_err_s;
    end
  end

  assign fl2rn_instr0prd       = ent_r[spec_head_r[IDX_W-1:0]];
  assign fl2rn_instr1prd       = ent_r[head1_idx_s];
  assign fl2rn_instr0prd_valid = (count_s != PTR_W'(0));
  assign fl2rn_instr1prd_valid = (count_s >= PTR_W'(2));
  assign fl_count              = count_s;
  assign fl_err                = err_r;

endmodule

// File: tb/tb_freelist.sv
// Self-checking bench for freelist: directed scenarios plus random traffic checked
// against a queue-based model of committed free registers and speculative offset.
module tb_freelist;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] prd0, prd1;
  logic       prd0_valid, prd1_valid;
  logic       alloc0, alloc1;
  logic       free0_valid, free1_valid;
  logic [5:0] free0_preg, free1_preg;
  logic [1:0] commit_cnt;
  logic       flush;
  logic [5:0] count;
  logic       err;

  int errors = 0;
  int checks = 0;

  // Model: queue holds entries from the committed head to the tail;
  // spec_off is how many of them rename has speculatively taken.
  int   q[$];
  int   spec_off;
  logic m_err;

  freelist dut (
    .clock                  (clock),
    .reset                  (reset),
    .fl2rn_instr0prd        (prd0),
    .fl2rn_instr0prd_valid  (prd0_valid),
    .fl2rn_instr1prd        (prd1),
    .fl2rn_instr1prd_valid  (prd1_valid),
    .rn2fl_instr0_alloc     (alloc0),
    .rn2fl_instr1_alloc     (alloc1),
    .rob2fl_free0_valid     (free0_valid),
    .rob2fl_free0_preg      (free0_preg),
    .rob2fl_free1_valid     (free1_valid),
    .rob2fl_free1_preg      (free1_preg),
    .rob2fl_commit_alloc_cnt(commit_cnt),
    .flush_valid            (flush),
    .fl_count               (count),
    .fl_err                 (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int avail;
    avail = q.size() - spec_off;
    chk("fl_count", 32'(count), 32'(avail));
    chk("prd0_valid", 32'(prd0_valid), 32'(avail >= 1));
    chk("prd1_valid", 32'(prd1_valid), 32'(avail >= 2));
    if (avail >= 1) chk("prd0", 32'(prd0), 32'(q[spec_off]));
    if (avail >= 2) chk("prd1", 32'(prd1), 32'(q[spec_off + 1]));
    chk("fl_err", 32'(err), 32'(m_err));
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
    spec_off = 0;
    m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    alloc0 = 1'b0; alloc1 = 1'b0;
    free0_valid = 1'b0; free0_preg = 6'd0;
    free1_valid = 1'b0; free1_preg = 6'd0;
    commit_cnt = 2'd0; flush = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    check_all();
  endtask

  task automatic step(input bit a0, input bit a1, input bit v0, input int p0,
                      input bit v1, input int p1, input int cc, input bit fl);
    int  avail, ncom, nalloc, nf;
    bit  aerr;
    alloc0 = a0; alloc1 = a1;
    free0_valid = v0; free0_preg = 6'(p0);
    free1_valid = v1; free1_preg = 6'(p1);
    commit_cnt = 2'(cc); flush = fl;
    @(posedge clock);
    avail = q.size() - spec_off;
    aerr = 1'b0;
    if (!fl && ((a1 && !a0) || (a0 && avail < 1) || (a1 && avail < 2))) aerr = 1'b1;
    nalloc = (fl || aerr) ? 0 : (int'(a0) + int'(a1));
    if (cc == 3) begin
      ncom = 0;
      m_err = 1'b1;
    end else begin
      ncom = cc;
      if (cc > spec_off) m_err = 1'b1;
    end
    nf = int'(v0) + int'(v1);
    repeat (ncom) void'(q.pop_front());
    spec_off = spec_off - ncom;
    if (nf > 0 && q.size() + nf > 32) begin
      m_err = 1'b1;
    end else begin
      if (v0) q.push_back(p0);
      if (v1) q.push_back(p1);
    end
    spec_off = fl ? 0 : spec_off + nalloc;
    if (aerr) m_err = 1'b1;
    #1;
    idle_inputs();
    check_all();
  endtask

  initial begin
    int avail, mx, n, cc, room, nf;
    bit fl, a0, a1;
    idle_inputs();
    reset = 1'b1;

    // Reset image and idle hold.
    reset_dut();
    chk("reset_prd0", 32'(prd0), 32'd32);
    chk("reset_prd1", 32'(prd1), 32'd33);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Drain completely, then over-allocate.
    repeat (16) step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("drained_count", 32'(count), 32'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("overalloc_err", 32'(err), 32'd1);
    chk("overalloc_count", 32'(count), 32'd0);

    // Free 5 and 9 at the tail, walk the head across the wrap.
    reset_dut();
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 5, 1, 9, 2, 0);
    repeat (15) step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("wrap_prd0", 32'(prd0), 32'd5);
    chk("wrap_prd1", 32'(prd1), 32'd9);
    chk("wrap_count", 32'(count), 32'd2);

    // Flush rolls back to the committed head.
    reset_dut();
    repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 1, 4, 2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("flush_prd0", 32'(prd0), 32'd34);
    chk("flush_prd1", 32'(prd1), 32'd35);
    chk("flush_count", 32'(count), 32'd32);

    // Alloc, free, commit and flush together.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 7, 0, 0, 1, 1);
    chk("combo_count", 32'(count), 32'd32);
    chk("combo_prd0", 32'(prd0), 32'd35);
    chk("combo_err", 32'(err), 32'd0);

    // Push onto a full list, then reset mid-sequence.
    reset_dut();
    step(0, 0, 1, 40, 0, 0, 0, 0);
    chk("overflow_err", 32'(err), 32'd1);
    chk("overflow_count", 32'(count), 32'd32);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    reset_dut();
    chk("rereset_err", 32'(err), 32'd0);

    // Randomized traffic, mostly legal with occasional protocol violations.
    reset_dut();
    for (int k = 0; k < 600; k++) begin
      avail = q.size() - spec_off;
      mx = (avail < 2) ? avail : 2;
      n = $urandom_range(mx, 0);
      a0 = (n >= 1); a1 = (n == 2);
      if (k > 300 && $urandom_range(40, 0) == 0) begin a0 = 1'b0; a1 = 1'b1; end
      mx = (spec_off < 2) ? spec_off : 2;
      cc = $urandom_range(mx, 0);
      if (k > 300 && $urandom_range(40, 0) == 0) cc = 3;
      room = 32 - (q.size() - ((cc == 3) ? 0 : cc));
      mx = (room < 2) ? room : 2;
      nf = $urandom_range(mx, 0);
      fl = ($urandom_range(7, 0) == 0);
      if (nf == 1 && $urandom_range(1, 0) == 1)
        step(a0, a1, 0, 0, 1, $urandom_range(63, 0), cc, fl);
      else
        step(a0, a1, nf >= 1, $urandom_range(63, 0), nf == 2, $urandom_range(63, 0), cc, fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
